// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//
// Execute-stage ALU. The logic and shift operations and ADD/SUB complete one
// cycle after they are accepted. Signed MUL (shift-add) and signed DIV
// (restoring) run iteratively, one bit per cycle. While one of those is in
// flight, in_ready is held low to stall the pipeline.
//
// Every accepted operation also produces two compare flags from A-B of its
// captured operands, and an exception flag.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   in_valid        an operation is presented this cycle
//   in_ready        the block can accept an operation this cycle
//   data_operandA   operand A (two's complement)
//   data_operandB   operand B (two's complement)
//   ctrl_ALUopcode  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, 6 MUL, 7 DIV,
//                   8 SRL, 9 XOR; 10-31 give result 0
//   ctrl_shiftamt   shift amount for SLL/SRL/SRA
//   out_valid       one-cycle pulse: result and flags are valid
//   data_result     result (held between pulses)
//   isNotEqual      A != B
//   isLessThan      signed A < B, corrected for overflow of A-B
//   data_exception  ADD/SUB/MUL signed overflow, or DIV by zero / MIN / -1
// -----------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               data_exception
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6;
    localparam logic [4:0] OP_DIV = 5'd7;
    localparam logic [4:0] OP_SRL = 5'd8;
    localparam logic [4:0] OP_XOR = 5'd9;

    localparam logic [SHAMT_W-1:0] CNT_START = SHAMT_W'(WIDTH - 1);
    localparam logic [SHAMT_W-1:0] CNT_ONE   = SHAMT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2
    } state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e             state_q,     state_d;
    logic [SHAMT_W-1:0] count_q,     count_d;
    logic [WIDTH-1:0]   hi_q,        hi_d;
    logic [WIDTH-1:0]   lo_q,        lo_d;
    logic [WIDTH-1:0]   opnd_q,      opnd_d;
    logic               neg_q,       neg_d;
    logic               ne_pend_q,   ne_pend_d;
    logic               lt_pend_q,   lt_pend_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               ne_q,        ne_d;
    logic               lt_q,        lt_d;
    logic               exc_q,       exc_d;

    logic accept;
    logic is_mul;
    logic is_div;
    logic start;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mul   = (ctrl_ALUopcode == OP_MUL);
    assign is_div   = (ctrl_ALUopcode == OP_DIV);
    assign start    = accept & (is_mul | is_div);

    // ---------------------------------------------------------------------
    // Compare flags: computed for every accepted op from A-B
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] diff;
    logic             cmp_ovf;
    logic             cmp_lt;
    logic             cmp_ne;

    assign diff    = data_operandA - data_operandB;
    assign cmp_ovf = (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]) &
                     (diff[WIDTH-1] ^ data_operandA[WIDTH-1]);
    assign cmp_lt  = diff[WIDTH-1] ^ cmp_ovf;
    assign cmp_ne  = |diff;

    // ---------------------------------------------------------------------
    // Single-cycle operations
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [WIDTH-1:0] sc_result;
    logic             sc_exc;

    assign sum     = data_operandA + data_operandB;
    assign add_ovf = ~(data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]) &
                     (sum[WIDTH-1] ^ data_operandA[WIDTH-1]);

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        sc_result = '0;
        sc_exc    = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                sc_result = sum;
                sc_exc    = add_ovf;
            end
            OP_SUB: begin
                sc_result = diff;
                sc_exc    = cmp_ovf;
            end
            OP_AND:  sc_result = data_operandA & data_operandB;
            OP_OR:   sc_result = data_operandA | data_operandB;
            OP_XOR:  sc_result = data_operandA ^ data_operandB;
            OP_SLL:  sc_result = data_operandA << ctrl_shiftamt;
            OP_SRL:  sc_result = data_operandA >> ctrl_shiftamt;
            OP_SRA:  sc_result = $signed(data_operandA) >>> ctrl_shiftamt;
            default: begin
                sc_result = '0;
                sc_exc    = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Iteration datapath, shared by MUL and DIV
    //   MUL: hi = partial product high half, lo = multiplier shifting out /
    //        product low half shifting in, opnd = |A|.
    //   DIV: hi = partial remainder, lo = dividend shifting out / quotient
    //        shifting in, opnd = |B|.
    // The accept edge already performs the first iteration on the live
    // operands, so the remaining WIDTH-1 iterations fit in WIDTH-1 busy cycles.
    // ---------------------------------------------------------------------
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = data_operandA[WIDTH-1];
    assign b_neg = data_operandB[WIDTH-1];
    assign a_mag = a_neg ? -data_operandA : data_operandA;
    assign b_mag = b_neg ? -data_operandB : data_operandB;

    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] it_op;
    logic             it_div;

    always_comb begin
        it_hi  = hi_q;
        it_lo  = lo_q;
        it_op  = opnd_q;
        it_div = (state_q == S_DIV_RUN);
        if (start) begin
            it_hi  = '0;
            it_lo  = is_mul ? b_mag : a_mag;
            it_op  = is_mul ? a_mag : b_mag;
            it_div = is_div;
        end
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign mul_sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, it_op} : '0);
    assign div_shift = {it_hi, it_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, it_op};

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], it_lo[WIDTH-1:1]};
        if (it_div) begin
            // Restoring division: keep the trial remainder only when it did
            // not go negative, and shift in the matching quotient bit.
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {it_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {it_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Final sign fix-up, evaluated on the last iteration's output
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] mul_res;
    logic             mul_exc;
    logic             div_by_zero;
    logic [WIDTH-1:0] div_res;
    logic             div_exc;

    assign mul_res = neg_q ? -step_lo : step_lo;
    // A negative product may reach exactly -2^(WIDTH-1); a positive one must
    // stay below 2^(WIDTH-1).
    assign mul_exc = (|step_hi) |
                     (neg_q ? (step_lo[WIDTH-1] & (|step_lo[WIDTH-2:0]))
                            : step_lo[WIDTH-1]);

    assign div_by_zero = (opnd_q == '0);
    assign div_res     = div_by_zero ? '0 : (neg_q ? -step_lo : step_lo);
    // A non-negative quotient with its MSB set only arises from MIN / -1.
    assign div_exc     = div_by_zero | (~neg_q & step_lo[WIDTH-1]);

    // ---------------------------------------------------------------------
    // FSM next state and output-register loads
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        neg_d       = neg_q;
        ne_pend_d   = ne_pend_q;
        lt_pend_d   = lt_pend_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        ne_d        = ne_q;
        lt_d        = lt_q;
        exc_d       = exc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = is_mul ? S_MUL_RUN : S_DIV_RUN;
                    count_d   = CNT_START;
                    hi_d      = step_hi;
                    lo_d      = step_lo;
                    opnd_d    = it_op;
                    neg_d     = a_neg ^ b_neg;
                    ne_pend_d = cmp_ne;
                    lt_pend_d = cmp_lt;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = sc_result;
                    exc_d       = sc_exc;
                    ne_d        = cmp_ne;
                    lt_d        = cmp_lt;
                end
            end

            S_MUL_RUN, S_DIV_RUN: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q - CNT_ONE;
                // count holds the iterations still to run; this one is the last.
                if (count_q == CNT_ONE) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = (state_q == S_DIV_RUN) ? div_res : mul_res;
                    exc_d       = (state_q == S_DIV_RUN) ? div_exc : mul_exc;
                    ne_d        = ne_pend_q;
                    lt_d        = lt_pend_q;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            ne_pend_q   <= 1'b0;
            lt_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ne_q        <= 1'b0;
            lt_q        <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            neg_q       <= neg_d;
            ne_pend_q   <= ne_pend_d;
            lt_pend_q   <= lt_pend_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ne_q        <= ne_d;
            lt_q        <= lt_d;
            exc_q       <= exc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign data_result    = result_q;
    assign isNotEqual     = ne_q;
    assign isLessThan     = lt_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//
// Directed and randomized checks of alu_multicycle (WIDTH=32) against a
// behavioural model that works in plain signed 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic               clock;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [4:0]         opcode;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic [WIDTH-1:0]   data_result;
    logic               is_not_equal;
    logic               is_less_than;
    logic               data_exception;

    int tests_run    = 0;
    int tests_failed = 0;

    // Outputs captured at the most recent out_valid pulse of run_op.
    logic [31:0] obs_res;
    logic        obs_exc;
    logic        obs_ne;
    logic        obs_lt;

    logic [31:0] corners [6];

    alu_multicycle #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_ALUopcode (opcode),
        .ctrl_shiftamt  (shamt),
        .out_valid      (out_valid),
        .data_result    (data_result),
        .isNotEqual     (is_not_equal),
        .isLessThan     (is_less_than),
        .data_exception (data_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: operation semantics in signed 64-bit arithmetic.
    function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] res, output logic exc,
                                  output logic ne, output logic lt);
        longint sa;
        longint sb;
        longint full;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        exc = 1'b0;
        ne  = (a != b);
        lt  = (sa < sb);
        case (op)
            5'd0: begin
                full = sa + sb;
                res  = full[31:0];
                exc  = (full > MAX_S) || (full < MIN_S);
            end
            5'd1: begin
                full = sa - sb;
                res  = full[31:0];
                exc  = (full > MAX_S) || (full < MIN_S);
            end
            5'd2: res = a & b;
            5'd3: res = a | b;
            5'd4: res = a << sh;
            5'd5: res = $signed(a) >>> sh;
            5'd6: begin
                full = sa * sb;
                res  = full[31:0];
                exc  = (full > MAX_S) || (full < MIN_S);
            end
            5'd7: begin
                if (b == 32'd0) begin
                    res = '0;
                    exc = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = 32'h8000_0000;
                    exc = 1'b1;
                end else begin
                    full = sa / sb;
                    res  = full[31:0];
                end
            end
            5'd8: res = a >> sh;
            5'd9: res = a ^ b;
            default: begin
                res = '0;
                exc = 1'b0;
            end
        endcase
    endfunction

    // Issue one operation, wait for its result within a cycle budget, and
    // check latency, stall length, outputs and that outputs hold afterwards.
    // With hold set, in_valid stays high (with junk operands) while busy.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit hold);
        logic [31:0] e_res;
        logic        e_exc;
        logic        e_ne;
        logic        e_lt;
        int          e_lat;
        int          lat;
        int          busy;
        int          extra;
        bit          got;
        logic        rdy_at_valid;

        model(op, a, b, sh, e_res, e_exc, e_ne, e_lt);
        e_lat = (op == 5'd6 || op == 5'd7) ? WIDTH : 1;

        @(negedge clock);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        opcode   = op;
        shamt    = sh;
        @(posedge clock);
        #1;
        // Operands are captured on the accept edge; scramble them now.
        in_valid = hold;
        op_a     = $urandom;
        op_b     = $urandom;
        opcode   = 5'($urandom);
        shamt    = 5'($urandom);

        got          = 1'b0;
        lat          = 0;
        busy         = 0;
        rdy_at_valid = 1'b0;
        for (int k = 1; k <= e_lat + 8 && !got; k++) begin
            @(negedge clock);
            if (out_valid) begin
                got          = 1'b1;
                lat          = k;
                rdy_at_valid = in_ready;
                obs_res      = data_result;
                obs_exc      = data_exception;
                obs_ne       = is_not_equal;
                obs_lt       = is_less_than;
                in_valid     = 1'b0;
            end else if (!in_ready) begin
                busy++;
            end
        end
        in_valid = 1'b0;

        check({tag, "_seen"},  32'(got),          32'd1);
        check({tag, "_lat"},   32'(lat),          32'(e_lat));
        check({tag, "_busy"},  32'(busy),         32'(e_lat - 1));
        check({tag, "_rdy"},   32'(rdy_at_valid), 32'd1);
        check({tag, "_res"},   obs_res,           e_res);
        check({tag, "_exc"},   32'(obs_exc),      32'(e_exc));
        check({tag, "_ne"},    32'(obs_ne),       32'(e_ne));
        check({tag, "_lt"},    32'(obs_lt),       32'(e_lt));

        extra = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (out_valid) extra++;
        end
        check({tag, "_pulse"}, 32'(extra),       32'd0);
        check({tag, "_hold"},  data_result,      e_res);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        if ($urandom_range(0, 3) == 0) begin
            v = corners[$urandom_range(0, 5)];
        end else if ($urandom_range(0, 1) == 0) begin
            v = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 1) v = -v;
        end else begin
            v = $urandom;
        end
        return v;
    endfunction

    initial begin
        logic [31:0] e_res;
        logic        e_exc;
        logic        e_ne;
        logic        e_lt;
        logic [31:0] bb_a [3];
        logic [31:0] bb_b [3];
        int          stray;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0001_0000;

        reset    = 1'b1;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        opcode   = '0;
        shamt    = '0;

        // Reset state
        #1;
        check("rst_ready",  32'(in_ready),       32'd1);
        check("rst_valid",  32'(out_valid),      32'd0);
        check("rst_result", data_result,         32'd0);
        check("rst_exc",    32'(data_exception), 32'd0);
        check("rst_ne",     32'(is_not_equal),   32'd0);
        check("rst_lt",     32'(is_less_than),   32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // ADD / SUB
        run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
        check("add_ovf_const_res", obs_res,       32'h8000_0000);
        check("add_ovf_const_exc", 32'(obs_exc),  32'd1);
        run_op("sub_neg", 5'd1, 32'd5, 32'd7, 5'd0, 1'b0);
        check("sub_neg_const_res", obs_res,       32'hFFFF_FFFE);
        check("sub_neg_const_lt",  32'(obs_lt),   32'd1);
        check("sub_neg_const_ne",  32'(obs_ne),   32'd1);
        run_op("sub_ovf", 5'd1, 32'h8000_0000, 32'd1, 5'd0, 1'b0);

        // Shifts use ctrl_shiftamt, never B
        run_op("sll", 5'd4, 32'h0000_0001, 32'h0000_0003, 5'd31, 1'b0);
        check("sll_const_res", obs_res, 32'h8000_0000);
        run_op("sra", 5'd5, 32'h8000_0000, 32'h0000_0001, 5'd4, 1'b0);
        check("sra_const_res", obs_res, 32'hF800_0000);
        run_op("srl", 5'd8, 32'h8000_0000, 32'h0000_0001, 5'd4, 1'b0);
        check("srl_const_res", obs_res, 32'h0800_0000);

        // Logic ops, overflow-corrected compare, unused opcode
        run_op("and_cmp", 5'd2, 32'h8000_0000, 32'h0000_0001, 5'd0, 1'b0);
        check("cmp_ovf_lt", 32'(obs_lt), 32'd1);
        run_op("or",  5'd3, 32'hF0F0_1234, 32'h0F0F_4321, 5'd0, 1'b0);
        run_op("xor", 5'd9, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 1'b0);
        run_op("op15", 5'd15, 32'h1234_5678, 32'h1234_5678, 5'd3, 1'b0);

        // MUL
        run_op("mul_neg", 5'd6, 32'hFFFF_FFF9, 32'd6, 5'd0, 1'b0);
        check("mul_neg_const_res", obs_res,      32'hFFFF_FFD6);
        check("mul_neg_const_exc", 32'(obs_exc), 32'd0);
        run_op("mul_ovf", 5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0);
        check("mul_ovf_const_exc", 32'(obs_exc), 32'd1);
        run_op("mul_min1", 5'd6, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
        run_op("mul_minm1", 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);

        // DIV (first one with in_valid held high while busy)
        run_op("div_neg", 5'd7, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
        check("div_neg_const_res", obs_res, 32'hFFFF_FFFD);
        run_op("div_zero", 5'd7, 32'd9, 32'd0, 5'd0, 1'b1);
        check("div_zero_const_res", obs_res,      32'd0);
        check("div_zero_const_exc", 32'(obs_exc), 32'd1);
        run_op("div_minm1", 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
        check("div_minm1_const_res", obs_res,      32'h8000_0000);
        check("div_minm1_const_exc", 32'(obs_exc), 32'd1);

        // Reset in the middle of a MUL
        @(negedge clock);
        in_valid = 1'b1;
        op_a     = 32'd1234;
        op_b     = 32'hFFFF_FF00;
        opcode   = 5'd6;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_ready",  32'(in_ready),       32'd1);
        check("midrst_valid",  32'(out_valid),      32'd0);
        check("midrst_result", data_result,         32'd0);
        check("midrst_exc",    32'(data_exception), 32'd0);
        check("midrst_ne",     32'(is_not_equal),   32'd0);
        check("midrst_lt",     32'(is_less_than),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < WIDTH + 8; k++) begin
            @(negedge clock);
            if (out_valid) stray++;
        end
        check("midrst_no_valid", 32'(stray), 32'd0);

        // Three back-to-back ADDs
        for (int i = 0; i < 3; i++) begin
            bb_a[i] = $urandom;
            bb_b[i] = $urandom;
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op_a     = bb_a[i];
            op_b     = bb_b[i];
            opcode   = 5'd0;
            @(negedge clock);
            model(5'd0, bb_a[i], bb_b[i], 5'd0, e_res, e_exc, e_ne, e_lt);
            check($sformatf("b2b%0d_valid", i), 32'(out_valid),      32'd1);
            check($sformatf("b2b%0d_res", i),   data_result,         e_res);
            check($sformatf("b2b%0d_exc", i),   32'(data_exception), 32'(e_exc));
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("b2b_tail_valid", 32'(out_valid), 32'd0);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            logic [4:0] r_op;
            int         sel;
            sel = $urandom_range(0, 13);
            r_op = (sel >= 10) ? 5'($urandom_range(10, 31)) : 5'(sel);
            run_op($sformatf("rnd%0d_op%0d", n, r_op), r_op, pick_operand(),
                   pick_operand(), 5'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
